// File: rtl/seq_detect_pkg.sv
// Shared types for the parametrised serial pattern detector.
// Holds the FSM state encoding used by seq_detect_param.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_FULL  = 2'd2,
        S_MATCH = 2'd3
    } seq_state_t;

    // Bits needed to count 0..n inclusive.
    function automatic int fill_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_detect_hist.sv
// History shift register, fill counter and pattern compare.
// Ports: clk/reset, clr (drop window), restart (new window at x),
//   accept (qualified bit), x, pat; outputs match_nxt, fill_full_nxt.
module seq_detect_hist
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             restart,
    input  logic             accept,
    input  logic             x,
    input  logic [PAT_W-1:0] pat,
    output logic             match_nxt,
    output logic             fill_full_nxt
);

    localparam int FW = fill_width(PAT_W);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_nxt;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_nxt;

    always_comb begin
        hist_nxt = hist;
        fill_nxt = fill;
        if (clr) begin
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (restart) begin
            // Non-overlapping exit: any accepted bit opens a new window.
            hist_nxt = accept ? {{(PAT_W-1){1'b0}}, x} : '0;
            fill_nxt = accept ? FW'(1) : '0;
        end else if (accept) begin
            hist_nxt = {hist[PAT_W-2:0], x};
            fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else begin
            hist <= hist_nxt;
            fill <= fill_nxt;
        end
    end

    assign fill_full_nxt = (fill_nxt == FULL);
    assign match_nxt     = fill_full_nxt && (hist_nxt == pat);

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-loadable serial pattern detector, Moore match pulse z.
// Ports: clk, reset, x, x_valid, overlap, pat_load, pat_in,
//   z, state_o, match_count. Counter built only with SEQ_MATCH_CNT_EN.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             z,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] match_count
);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [PAT_W-1:0] pat;
    logic             accept;
    logic             restart;
    logic             match_nxt;
    logic             fill_full_nxt;

    // A bit arriving with pat_load is discarded.
    assign accept  = x_valid & ~pat_load;
    assign restart = (state == S_MATCH) & ~overlap;

    seq_detect_hist #(
        .PAT_W(PAT_W)
    ) u_hist (
        .clk          (clk),
        .reset        (reset),
        .clr          (pat_load),
        .restart      (restart),
        .accept       (accept),
        .x            (x),
        .pat          (pat),
        .match_nxt    (match_nxt),
        .fill_full_nxt(fill_full_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset)
            pat <= PAT_RST;
        else if (pat_load)
            pat <= pat_in;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        priority case (1'b1)
            pat_load: state_nxt = S_EMPTY;
            accept: begin
                if (match_nxt)
                    state_nxt = S_MATCH;
                else if (!fill_full_nxt)
                    state_nxt = S_FILL;
                else
                    state_nxt = S_FULL;
            end
            // Never hold S_MATCH without a new match.
            (state == S_MATCH):
                state_nxt = overlap ? S_FULL : S_EMPTY;
            default: state_nxt = state;
        endcase
    end

    assign z       = (state == S_MATCH);
    assign state_o = state;

`ifdef SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (state_nxt == S_MATCH && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param (4-bit and 3-bit instances).
// Table vectors plus gap, load and saturation sequences.
module tb_seq_detect_param;

`ifdef SEQ_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       x, x_valid, overlap, pat_load;
    logic [3:0] pat_in;
    logic       z;
    logic [1:0] state_o;
    logic [1:0] match_count;

    logic       x3, v3;
    logic       z3;
    logic [1:0] st3;
    logic [7:0] cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_param #(
        .PAT_W(4), .PAT_RST(4'b1011), .CNT_W(2)
    ) u_dut (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .z(z), .state_o(state_o), .match_count(match_count)
    );

    seq_detect_param #(
        .PAT_W(3), .PAT_RST(3'b011), .CNT_W(8)
    ) u_dut3 (
        .clk(clk), .reset(reset), .x(x3), .x_valid(v3),
        .overlap(1'b1), .pat_load(1'b0), .pat_in(3'b000),
        .z(z3), .state_o(st3), .match_count(cnt3)
    );

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] pin;
        logic       xb;
        logic       v;
        logic       ov;
        logic       ez;
        logic [1:0] est;
        logic [1:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ce(input int n);
        return CNT_ON ? n : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic l, input logic [3:0] p,
                         input logic b, input logic v, input logic o);
        reset = r; pat_load = l; pat_in = p;
        x = b; x_valid = v; overlap = o;
    endtask

    task automatic add(input logic r, input logic l, input logic [3:0] p,
                       input logic b, input logic v, input logic o,
                       input logic ez, input logic [1:0] est,
                       input logic [1:0] ecnt);
        vecs.push_back('{r, l, p, b, v, o, ez, est, ecnt});
    endtask

    initial begin
        int pulses;
        logic [3:0] pat;

        drive(1, 0, 4'h0, 0, 0, 1);
        x3 = 0; v3 = 0;

        // T0: reset pattern 1011, overlap exit keeps history
        add(1,0,4'h0, 0,0,1, 0,0,0);
        add(0,0,4'h0, 1,1,1, 0,1,0);
        add(0,0,4'h0, 0,1,1, 0,1,0);
        add(0,0,4'h0, 1,1,1, 0,1,0);
        add(0,0,4'h0, 1,1,1, 1,3,1);
        add(0,0,4'h0, 0,0,1, 0,2,1);
        add(0,0,4'h0, 0,1,1, 0,2,1);
        add(0,0,4'h0, 1,1,1, 0,2,1);
        add(0,0,4'h0, 1,1,1, 1,3,2);
        // T2: 1010 overlapping on 1010101
        add(1,0,4'h0, 0,0,1, 0,0,0);
        add(0,1,4'hA, 0,0,1, 0,0,0);
        add(0,0,4'h0, 1,1,1, 0,1,0);
        add(0,0,4'h0, 0,1,1, 0,1,0);
        add(0,0,4'h0, 1,1,1, 0,1,0);
        add(0,0,4'h0, 0,1,1, 1,3,1);
        add(0,0,4'h0, 1,1,1, 0,2,1);
        add(0,0,4'h0, 0,1,1, 1,3,2);
        add(0,0,4'h0, 1,1,1, 0,2,2);
        add(0,0,4'h0, 0,0,1, 0,2,2);
        // T3: same stream, non-overlapping
        add(1,0,4'h0, 0,0,0, 0,0,0);
        add(0,1,4'hA, 0,0,0, 0,0,0);
        add(0,0,4'h0, 1,1,0, 0,1,0);
        add(0,0,4'h0, 0,1,0, 0,1,0);
        add(0,0,4'h0, 1,1,0, 0,1,0);
        add(0,0,4'h0, 0,1,0, 1,3,1);
        add(0,0,4'h0, 1,1,0, 0,1,1);
        add(0,0,4'h0, 0,1,0, 0,1,1);
        add(0,0,4'h0, 1,1,0, 0,1,1);
        add(0,0,4'h0, 0,0,0, 0,1,1);
        // T5: load 1100 with coincident bit, then 1100
        add(1,0,4'h0, 0,0,0, 0,0,0);
        add(0,0,4'h0, 1,1,0, 0,1,0);
        add(0,0,4'h0, 0,1,0, 0,1,0);
        add(0,0,4'h0, 1,1,0, 0,1,0);
        add(0,1,4'hC, 1,1,0, 0,0,0);
        add(0,0,4'h0, 1,1,0, 0,1,0);
        add(0,0,4'h0, 1,1,0, 0,1,0);
        add(0,0,4'h0, 0,1,0, 0,1,0);
        add(0,0,4'h0, 0,1,0, 1,3,1);
        add(0,0,4'h0, 0,0,0, 0,0,1);
        add(0,0,4'h0, 1,0,0, 0,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].pin,
                  vecs[i].xb, vecs[i].v, vecs[i].ov);
            tick();
            chk($sformatf("vec%0d.z", i), int'(z), int'(vecs[i].ez));
            chk($sformatf("vec%0d.state", i), int'(state_o),
                int'(vecs[i].est));
            chk($sformatf("vec%0d.cnt", i), int'(match_count),
                ce(int'(vecs[i].ecnt)));
        end

        // T4: 1010 with 2-cycle gaps; x toggles while invalid
        drive(1, 0, 4'h0, 0, 0, 1); tick();
        drive(0, 1, 4'hA, 0, 0, 1); tick();
        pat = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 4'h0, pat[3-i], 1, 1);
            tick();
            chk($sformatf("t4.bit%0d.z", i), int'(z), (i == 3) ? 1 : 0);
            chk($sformatf("t4.bit%0d.st", i), int'(state_o),
                (i == 3) ? 3 : 1);
            for (int g = 0; g < 2; g++) begin
                drive(0, 0, 4'h0, ~pat[3-i], 0, 1);
                tick();
                chk($sformatf("t4.gap%0d_%0d.z", i, g), int'(z), 0);
                chk($sformatf("t4.gap%0d_%0d.st", i, g), int'(state_o),
                    (i == 3) ? 2 : 1);
            end
        end
        chk("t4.cnt", int'(match_count), ce(1));

        // T6: 1111 overlapping, 10 ones, counter saturates at 3
        drive(1, 0, 4'h0, 0, 0, 1); tick();
        drive(0, 1, 4'hF, 0, 0, 1); tick();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 4'h0, 1, 1, 1);
            tick();
            if (z) pulses++;
            chk($sformatf("t6.one%0d.z", i), int'(z), (i >= 3) ? 1 : 0);
        end
        chk("t6.pulses", pulses, 7);
        chk("t6.cnt_sat", int'(match_count), ce(3));
        drive(0, 0, 4'h0, 1, 1, 1); tick();
        drive(0, 0, 4'h0, 1, 1, 1); tick();
        drive(1, 0, 4'h0, 1, 1, 1); tick();
        chk("t6.rst.z", int'(z), 0);
        chk("t6.rst.st", int'(state_o), 0);
        chk("t6.rst.cnt", int'(match_count), 0);
        pat = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 4'h0, pat[3-i], 1, 1);
            tick();
            chk($sformatf("t6.patrst%0d.z", i), int'(z),
                (i == 3) ? 1 : 0);
        end
        chk("t6.patrst.cnt", int'(match_count), ce(1));

        // T1: 3-bit instance, pattern 011
        drive(1, 0, 4'h0, 0, 0, 1); tick();
        drive(0, 0, 4'h0, 0, 0, 1);
        chk("t1.rst.st", int'(st3), 0);
        pat = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            x3 = pat[2-i]; v3 = 1;
            tick();
            chk($sformatf("t1.bit%0d.z", i), int'(z3), (i == 2) ? 1 : 0);
            chk($sformatf("t1.bit%0d.st", i), int'(st3),
                (i == 2) ? 3 : 1);
        end
        v3 = 0; x3 = 1;
        tick();
        chk("t1.after.z", int'(z3), 0);
        chk("t1.after.st", int'(st3), 2);
        chk("t1.cnt", int'(cnt3), ce(1));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
